// File: rtl/j1_dbus_io_pkg.sv
// Shared types for the j1 data-bus I/O block: register indices, STATUS layout, decode helper.
package j1_dbus_io_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_RXDATA = 2'd2,
    REG_TIMER  = 2'd3
  } reg_idx_e;

  localparam int unsigned STAT_RX_FULL     = 0;
  localparam int unsigned STAT_TX_EMPTY    = 1;
  localparam int unsigned STAT_TX_FULL     = 2;
  localparam int unsigned STAT_TX_OVERFLOW = 3;

  // Field order mirrors the STAT_* bit positions above.
  typedef struct packed {
    logic [11:0] rsvd;
    logic        tx_overflow;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_full;
  } status_t;

  localparam logic [2:0] IO_PAGE = 3'b111;

  function automatic logic io_hit(input logic [15:0] adr);
    return adr[14:12] == IO_PAGE;
  endfunction

endpackage

// File: rtl/if_dbus.sv
// j1 data bus: word address, read/write strobes, write data from core, read data from slave.
interface if_dbus;
  logic [15:0] adr;
  logic        re;
  logic        we;
  logic [15:0] dat_m;
  logic [15:0] dat_s;

  modport master (output adr, output re, output we, output dat_m, input dat_s);
  modport slave  (input adr, input re, input we, input dat_m, output dat_s);
endinterface

// File: rtl/j1_dbus_io_sync_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       din,
  output logic [width-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = count_q == CntW'(depth);
  assign empty = count_q == '0;
  assign count = count_q;
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  // Masked so an empty FIFO always presents zero.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/j1_dbus_io.sv
// Memory-mapped byte I/O for the j1 data bus: TX FIFO, one-byte RX holding register, timer.
// Define DBUS_IO_TIMER_EN to build the free-running 16-bit timer; otherwise TIMER reads zero.
module j1_dbus_io
  import j1_dbus_io_pkg::*;
#(
  parameter int unsigned tx_depth = 8
) (
  input  logic       clk,
  input  logic       reset,
  if_dbus.slave      dbus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  logic       hit, wr, rd;
  reg_idx_e   idx;
  logic       tx_push, tx_pop, tx_full, tx_empty, ovf_evt;
  logic       rx_take;
  logic [$clog2(tx_depth):0] tx_count;

  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [15:0] dat_s_q, dat_s_d;
  logic [15:0] timer_rd;
  logic [15:0] rdata;
  status_t     status;

  assign hit = io_hit(dbus.adr);
  assign idx = reg_idx_e'(dbus.adr[1:0]);
  // A combined re/we access is treated purely as a write.
  assign wr  = dbus.we & hit;
  assign rd  = dbus.re & ~dbus.we & hit;

  assign tx_push  = wr & (idx == REG_TXDATA);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_valid = ~tx_empty;
  assign ovf_evt  = tx_push & tx_full & ~tx_pop;

  assign rx_ready = ~rx_full_q;
  assign rx_take  = rx_valid & rx_ready;

  sync_fifo #(
    .width (8),
    .depth (tx_depth)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (dbus.dat_m[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_comb begin
    tx_ovf_d  = tx_ovf_q;
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rd && idx == REG_STATUS) begin
      tx_ovf_d = 1'b0;
    end
    // A new overflow on the clearing edge must not be lost.
    if (ovf_evt) begin
      tx_ovf_d = 1'b1;
    end
    if (rd && idx == REG_RXDATA) begin
      rx_full_d = 1'b0;
    end
    if (rx_take) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end
  end

  always_comb begin
    status             = '0;
    status.rx_full     = rx_full_q;
    status.tx_empty    = tx_empty;
    status.tx_full     = tx_full;
    status.tx_overflow = tx_ovf_q;
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      REG_TXDATA: rdata = '0;
      REG_STATUS: rdata = status;
      REG_RXDATA: rdata = {8'h00, rx_byte_q};
      REG_TIMER:  rdata = timer_rd;
    endcase
  end

  assign dat_s_d   = rd ? rdata : dat_s_q;
  assign dbus.dat_s = dat_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
      dat_s_q   <= '0;
    end else begin
      tx_ovf_q  <= tx_ovf_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
      dat_s_q   <= dat_s_d;
    end
  end

`ifdef DBUS_IO_TIMER_EN
  logic [15:0] timer_q, timer_d;

  assign timer_d  = (wr && idx == REG_TIMER) ? dbus.dat_m : timer_q + 16'd1;
  assign timer_rd = timer_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timer_rd = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{dbus.adr[15], dbus.adr[11:2], dbus.dat_m[15:8], tx_count};

endmodule
